alu_seq_exec: RTL and testbench

Execute stage that consumes the 4-bit alu_control produced by the ALU control decoder and performs the selected operation on two operands.
- Logic, add/sub, SLT, NOR and LUI complete in 1 cycle.
- MUL, DIV and MOD run on an iterative shift-add multiplier / restoring divider.
- A start/busy/done handshake lets the core stall during multi-cycle ops.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/muldiv_iter.sv | 120 ++++++++++++
 rtl/alu_seq_exec.sv | 180 ++++++++++++++++++
 tb/tb_alu_seq_exec.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: operation codes, FSM states and
// iterative-unit mode encoding.
package alu_pkg;

   typedef enum logic [3:0] {
      AND_OP = 4'b0000,
      OR_OP  = 4'b0001,
      ADD_OP = 4'b0010,
      SUB_OP = 4'b0110,
      SLT_OP = 4'b0111,
      LUI_OP = 4'b1000,
      MUL_OP = 4'b1001,
      DIV_OP = 4'b1010,
      MOD_OP = 4'b1011,
      NOR_OP = 4'b1100
   } alu_ops_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } exec_state_t;

   localparam logic MD_MUL = 1'b0;
   localparam logic MD_DIV = 1'b1;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider working on operand
// magnitudes, with sign correction applied on the outputs.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic [WIDTH-1:0] product,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic             run_q, run_d;
   logic             mode_q, mode_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             bz_q, bz_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sh_q, sh_d;

   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   trial;

   always_comb begin
      cnt_d  = cnt_q;
      run_d  = run_q;
      mode_d = mode_q;
      negq_d = negq_q;
      negr_d = negr_q;
      bz_d   = bz_q;
      a_d    = a_q;
      div_d  = div_q;
      acc_d  = acc_q;
      sh_d   = sh_q;
      mag_a  = a[WIDTH-1] ? -a : a;
      mag_b  = b[WIDTH-1] ? -b : b;
      trial  = {acc_q, sh_q[WIDTH-1]};

      if (go) begin
         cnt_d  = CW'(WIDTH - 1);
         run_d  = 1'b1;
         mode_d = mode;
         negq_d = a[WIDTH-1] ^ b[WIDTH-1];
         negr_d = a[WIDTH-1];
         bz_d   = (b == '0);
         a_d    = a;
         acc_d  = '0;
         div_d  = (mode == MD_MUL) ? mag_a : mag_b;
         sh_d   = (mode == MD_MUL) ? mag_b : mag_a;
      end else if (run_q) begin
         if (mode_q == MD_MUL) begin
            if (sh_q[0]) begin
               acc_d = acc_q + div_q;
            end
            div_d = div_q << 1;
            sh_d  = sh_q >> 1;
         end else begin
            // Partial remainder stays below the divisor, so the W-bit
            // subtraction of the low bits is exact.
            if (trial >= {1'b0, div_q}) begin
               acc_d = trial[WIDTH-1:0] - div_q;
               sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = trial[WIDTH-1:0];
               sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end
         end
         if (cnt_q == '0) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         run_q  <= 1'b0;
         mode_q <= MD_MUL;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         bz_q   <= 1'b0;
         a_q    <= '0;
         div_q  <= '0;
         acc_q  <= '0;
         sh_q   <= '0;
      end else begin
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         mode_q <= mode_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
         bz_q   <= bz_d;
         a_q    <= a_d;
         div_q  <= div_d;
         acc_q  <= acc_d;
         sh_q   <= sh_d;
      end
   end

   // High during the final iteration; outputs are valid from the next cycle.
   assign ready     = run_q && (cnt_q == '0);
   assign product   = negq_q ? -acc_q : acc_q;
   assign quotient  = bz_q ? '1 : (negq_q ? -sh_q : sh_q);
   assign remainder = bz_q ? a_q : (negr_q ? -acc_q : acc_q);

endmodule

// File: rtl/alu_seq_exec.sv
// ALU execute stage with start/busy/done handshake. Defining ALU_MULDIV_EN
// builds the iterative MUL/DIV/MOD path; otherwise those codes are illegal.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// CALC  | iterative unit running WIDTH iterations
// FIX   | sign-corrected result and flags loaded, done follows
module alu_seq_exec
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int LUI_SHIFT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic             illegal_op
);

   exec_state_t      state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;
   logic             ill_q, ill_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_legal;
   logic             is_md;

`ifdef ALU_MULDIV_EN
   logic             mdu_go, mdu_mode, mdu_ready;
   logic [WIDTH-1:0] mdu_prod, mdu_quot, mdu_rem;
   logic [WIDTH-1:0] md_res;
   logic [3:0]       md_op_q, md_op_d;
   logic             bz_q, bz_d;

   assign mdu_mode = (alu_control == MUL_OP) ? MD_MUL : MD_DIV;

   muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk       (clk),
      .rst_n     (rst_n),
      .go        (mdu_go),
      .mode      (mdu_mode),
      .a         (a),
      .b         (b),
      .ready     (mdu_ready),
      .product   (mdu_prod),
      .quotient  (mdu_quot),
      .remainder (mdu_rem)
   );
`endif

   always_comb begin
      alu_res   = '0;
      alu_legal = 1'b1;
      is_md     = 1'b0;
      case (alu_control)
         AND_OP: alu_res = a & b;
         OR_OP:  alu_res = a | b;
         ADD_OP: alu_res = a + b;
         SUB_OP: alu_res = a - b;
         SLT_OP: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         LUI_OP: alu_res = b << LUI_SHIFT;
         NOR_OP: alu_res = ~(a | b);
`ifdef ALU_MULDIV_EN
         MUL_OP, DIV_OP, MOD_OP: is_md = 1'b1;
`endif
         default: alu_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      dbz_d    = dbz_q;
      ill_d    = ill_q;
`ifdef ALU_MULDIV_EN
      mdu_go   = 1'b0;
      md_op_d  = md_op_q;
      bz_d     = bz_q;
      md_res   = '0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
`ifdef ALU_MULDIV_EN
               if (is_md) begin
                  mdu_go  = 1'b1;
                  md_op_d = alu_control;
                  bz_d    = (b == '0) && (alu_control != MUL_OP);
                  state_d = CALC;
               end else
`endif
               begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  dbz_d    = 1'b0;
                  ill_d    = ~alu_legal;
                  done_d   = 1'b1;
               end
            end
         end
`ifdef ALU_MULDIV_EN
         CALC: begin
            if (mdu_ready) begin
               state_d = FIX;
            end
         end
         FIX: begin
            case (md_op_q)
               MUL_OP:  md_res = mdu_prod;
               DIV_OP:  md_res = mdu_quot;
               default: md_res = mdu_rem;
            endcase
            result_d = md_res;
            zero_d   = (md_res == '0);
            dbz_d    = bz_q;
            ill_d    = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
         ill_q    <= ill_d;
      end
   end

`ifdef ALU_MULDIV_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         md_op_q <= '0;
         bz_q    <= 1'b0;
      end else begin
         md_op_q <= md_op_d;
         bz_q    <= bz_d;
      end
   end

   assign busy = (state_q == CALC) || (state_q == FIX);
`else
   assign busy = 1'b0;
`endif

   assign result      = result_q;
   assign zero        = zero_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized self-checking bench for alu_seq_exec against an arithmetic
// reference model; follows ALU_MULDIV_EN the same way the design does.
module tb_alu_seq_exec;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [3:0]   alu_control;
   logic [W-1:0] a, b;
   logic [W-1:0] result;
   logic         zero, busy, done, div_by_zero, illegal_op;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_seq_exec #(
      .WIDTH     (W),
      .LUI_SHIFT (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .alu_control (alu_control),
      .a           (a),
      .b           (b),
      .result      (result),
      .zero        (zero),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .illegal_op  (illegal_op)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output bit dz, output bit il,
                                 output int lat);
      int     xi, yi;
      longint p;
      xi  = x;
      yi  = y;
      r   = '0;
      dz  = 1'b0;
      il  = 1'b0;
      lat = 1;
      case (op)
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b0010: r = x + y;
         4'b0110: r = x - y;
         4'b0111: r = (xi < yi) ? 32'd1 : 32'd0;
         4'b1000: r = y << 16;
         4'b1100: r = ~(x | y);
`ifdef ALU_MULDIV_EN
         4'b1001: begin
            lat = W + 2;
            p   = longint'(xi) * longint'(yi);
            r   = p[31:0];
         end
         4'b1010, 4'b1011: begin
            lat = W + 2;
            if (y == 0) begin
               dz = 1'b1;
               r  = (op == 4'b1010) ? 32'hFFFF_FFFF : x;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               r = (op == 4'b1010) ? 32'h8000_0000 : 32'h0;
            end else begin
               r = (op == 4'b1010) ? xi / yi : xi % yi;
            end
         end
`endif
         default: il = 1'b1;
      endcase
   endfunction

   // Entered and left at a negedge; the next call may start in the done cycle.
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit inject);
      logic [W-1:0] er;
      bit           edz, eil;
      int           elat, n, busy_cnt;
      bit           got;
      model(op, av, bv, er, edz, eil, elat);
      start       = 1'b1;
      alu_control = op;
      a           = av;
      b           = bv;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      a        = $urandom;
      b        = $urandom;
      n        = 1;
      busy_cnt = 0;
      got      = 1'b0;
      while (n <= 100) begin
         if (busy) busy_cnt++;
         if (done) begin
            got = 1'b1;
            break;
         end
         if (inject && n == 5) begin
            start       = 1'b1;
            alu_control = 4'($urandom_range(0, 15));
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (!got) begin
         chk($sformatf("timeout op=%h", op), 64'(n), 64'(elat));
         return;
      end
      chk($sformatf("result op=%h a=%h b=%h", op, av, bv), 64'(result), 64'(er));
      chk($sformatf("zero op=%h", op), 64'(zero), 64'(er == 0));
      chk($sformatf("div_by_zero op=%h", op), 64'(div_by_zero), 64'(edz));
      chk($sformatf("illegal_op op=%h", op), 64'(illegal_op), 64'(eil));
      chk($sformatf("latency op=%h", op), 64'(n), 64'(elat));
      chk($sformatf("busy_cycles op=%h", op), 64'(busy_cnt), 64'((elat > 1) ? elat - 1 : 0));
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 6))
         0:       v = '0;
         1:       v = 32'h8000_0000;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'($urandom_range(0, 20));
         4:       v = -32'($urandom_range(1, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap, done_seen;
      rst_n       = 1'b0;
      start       = 1'b0;
      alu_control = '0;
      a           = '0;
      b           = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_result", 64'(result), 64'h0);
      chk("rst_zero", 64'(zero), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
      chk("rst_flags", 64'({div_by_zero, illegal_op}), 64'h0);
      rst_n = 1'b1;

      run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b0);
      run_op(4'b0110, 32'd5, 32'd5, 1'b0);
      run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, 1'b0);
      run_op(4'b1000, 32'h0, 32'h0000_1234, 1'b0);
      run_op(4'b1100, 32'h0, 32'h0, 1'b0);
      run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
      run_op(4'b0001, 32'hF000_0000, 32'h0000_000F, 1'b0);
      run_op(4'b1001, 32'hFFFF_FFFD, 32'd7, 1'b1);
      run_op(4'b1010, -32'd7, 32'd2, 1'b0);
      run_op(4'b1011, -32'd7, 32'd2, 1'b0);
      run_op(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(4'b1010, 32'd5, 32'd0, 1'b0);
      run_op(4'b1011, 32'd5, 32'd0, 1'b0);
      run_op(4'b0010, 32'd1, 32'd2, 1'b0);
      run_op(4'b1111, 32'd3, 32'd4, 1'b0);
      run_op(4'b1001, 32'h1234_5678, 32'h8765_4321, 1'b0);

      // Reset in the middle of a divide after flags and result are non-zero.
      run_op(4'b1100, 32'h0, 32'h0, 1'b0);
      run_op(4'b1010, 32'd5, 32'd0, 1'b0);
      start       = 1'b1;
      alu_control = 4'b1010;
      a           = 32'd100;
      b           = 32'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'h0);
      chk("midrst_done", 64'(done), 64'h0);
      chk("midrst_result", 64'(result), 64'h0);
      chk("midrst_flags", 64'({zero, div_by_zero, illegal_op}), 64'h0);
      rst_n     = 1'b1;
      done_seen = 0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (done) done_seen++;
      end
      chk("midrst_no_done", 64'(done_seen), 64'h0);

      for (int i = 0; i < 150; i++) begin
         run_op(4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 3) == 0);
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            @(posedge clk);
            @(negedge clk);
            chk("done_pulse", 64'({done, busy}), 64'h0);
            repeat (gap - 1) begin
               @(posedge clk);
               @(negedge clk);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
